cdc_sync_multi: RTL and testbench

Multi-channel successor to the team's single-bit CDC synchronizer. It brings NCH independent asynchronous 1-bit signals into the clk domain through a STAGES-deep flop chain per channel. Each synchronized value then passes a per-channel stability (glitch) filter, and the block emits registered rise/fall pulses. It sits at clock-domain and pad boundaries, feeding status, interrupt and control logic.

---
 rtl/cdc_sync_pkg.sv | 8 +
 rtl/cdc_sync_chan.sv | 46 ++++
 rtl/cdc_sync_multi.sv | 52 +++++
 tb/tb_cdc_sync_multi.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cdc_sync_pkg.sv
// cdc_sync_pkg: shared constants, filter-counter sizing and edge encoding for cdc_sync_multi
package cdc_sync_pkg;
    localparam int CDC_MIN_STAGES = 2;
    typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} edge_t;
    function automatic int cnt_width(input int filt_cyc);
        return $clog2(filt_cyc + 1);
    endfunction
endpackage

// File: rtl/cdc_sync_chan.sv
// cdc_sync_chan: one channel's synchronizer chain, stability filter and registered edge pulses
module cdc_sync_chan
    import cdc_sync_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter int   FILT_CYC = 4,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  d,
    output logic  q,
    output logic  rise,
    output logic  fall,
    output edge_t edge_nx
);
    localparam int CW = cnt_width(FILT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);
    if (STAGES < CDC_MIN_STAGES) begin : g_bad_stages
        $error("cdc_sync_chan: STAGES must be >= %0d", CDC_MIN_STAGES);
    end
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
    logic [CW-1:0] cnt, cnt_nx;
    logic sync, hit;
    assign sync = chain[STAGES-1];
    always_comb begin
        hit     = (sync != q) && (cnt == CNT_LAST);
        cnt_nx  = (sync == q || hit) ? '0 : cnt + CW'(1);
        edge_nx = !hit ? EDGE_NONE : sync ? EDGE_RISE : EDGE_FALL;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {STAGES{RST_VAL}};
            cnt   <= '0;
            q     <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            cnt   <= cnt_nx;
            q     <= hit ? sync : q;
            rise  <= edge_nx == EDGE_RISE;
            fall  <= edge_nx == EDGE_FALL;
        end
    end
endmodule

// File: rtl/cdc_sync_multi.sv
// cdc_sync_multi: NCH-channel synchronizer + glitch filter + edge pulses; CDC_SYNC_STICKY_EN adds sticky event flags
module cdc_sync_multi
    import cdc_sync_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             STAGES   = 2,
    parameter int             FILT_CYC = 4,
    parameter logic [NCH-1:0] RST_VAL  = '0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] i_sig,
    output logic [NCH-1:0] o_sig_sync,
    output logic [NCH-1:0] o_rise,
    output logic [NCH-1:0] o_fall,
    output logic           o_any_chg
`ifdef CDC_SYNC_STICKY_EN
    ,
    input  logic [NCH-1:0] i_evt_clr,
    output logic [NCH-1:0] o_evt
`endif
);
    edge_t edg [NCH];
    logic [NCH-1:0] chg_nx;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        cdc_sync_chan #(
            .STAGES  (STAGES),
            .FILT_CYC(FILT_CYC),
            .RST_VAL (RST_VAL[g])
        ) u_chan (
            .clk    (clk),
            .rstn   (rstn),
            .d      (i_sig[g]),
            .q      (o_sig_sync[g]),
            .rise   (o_rise[g]),
            .fall   (o_fall[g]),
            .edge_nx(edg[g])
        );
        assign chg_nx[g] = edg[g] != EDGE_NONE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) o_any_chg <= 1'b0;
        else       o_any_chg <= |chg_nx;
    end
`ifdef CDC_SYNC_STICKY_EN
    // a new edge outranks a clear landing on the same cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) o_evt <= '0;
        else       o_evt <= chg_nx | (o_evt & ~i_evt_clr);
    end
`endif
endmodule

// File: tb/tb_cdc_sync_multi.sv
// tb_cdc_sync_multi: directed self-checking bench for cdc_sync_multi (defaults with RST_VAL=0101, plus FILT_CYC=1)
module tb_cdc_sync_multi;
    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] a_sig, a_sync, a_rise, a_fall;
    logic [3:0] b_sig, b_sync, b_rise, b_fall;
    logic       a_any, b_any;
    int         n_cmp = 0;
    int         n_err = 0;
`ifdef CDC_SYNC_STICKY_EN
    logic [3:0] a_clr, a_evt, b_evt;
`endif
    always #5 clk = ~clk;
    cdc_sync_multi #(.NCH(4), .STAGES(2), .FILT_CYC(4), .RST_VAL(4'b0101)) u_a (
        .clk       (clk),
        .rstn      (rstn),
        .i_sig     (a_sig),
        .o_sig_sync(a_sync),
        .o_rise    (a_rise),
        .o_fall    (a_fall),
        .o_any_chg (a_any)
`ifdef CDC_SYNC_STICKY_EN
        ,
        .i_evt_clr (a_clr),
        .o_evt     (a_evt)
`endif
    );
    cdc_sync_multi #(.NCH(4), .STAGES(2), .FILT_CYC(1), .RST_VAL(4'b0000)) u_b (
        .clk       (clk),
        .rstn      (rstn),
        .i_sig     (b_sig),
        .o_sig_sync(b_sync),
        .o_rise    (b_rise),
        .o_fall    (b_fall),
        .o_any_chg (b_any)
`ifdef CDC_SYNC_STICKY_EN
        ,
        .i_evt_clr (4'b0000),
        .o_evt     (b_evt)
`endif
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    initial begin
        rstn  = 1'b0;
        a_sig = 4'hF;
        b_sig = 4'h0;
`ifdef CDC_SYNC_STICKY_EN
        a_clr = 4'h0;
`endif
        tick();
        tick();
        chk("rst_sync", {4'h0, a_sync}, 8'h05);
        chk("rst_pulse", {a_rise, a_fall}, 8'h00);
        chk("rst_any", {7'h0, a_any}, 8'h00);
        rstn = 1'b1;
        // reset mismatch on ch1/ch3 is filtered like any change
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("rel_sync_%0d", k), {4'h0, a_sync}, (k >= 6) ? 8'h0F : 8'h05);
            chk($sformatf("rel_rise_%0d", k), {a_rise, a_fall}, (k == 6) ? 8'hA0 : 8'h00);
            chk($sformatf("rel_any_%0d", k), {7'h0, a_any}, (k == 6) ? 8'h01 : 8'h00);
        end
`ifdef CDC_SYNC_STICKY_EN
        chk("rel_evt", {4'h0, a_evt}, 8'h0A);
`endif
        a_sig = 4'hE;
        repeat (8) tick();
        chk("lat_pre", {4'h0, a_sync}, 8'h0E);
        a_sig = 4'hF;
        b_sig = 4'h1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("lat_a_sync_%0d", k), {4'h0, a_sync}, (k == 6) ? 8'h0F : 8'h0E);
            chk($sformatf("lat_a_rise_%0d", k), {4'h0, a_rise}, (k == 6) ? 8'h01 : 8'h00);
            chk($sformatf("lat_b_sync_%0d", k), {4'h0, b_sync}, (k >= 3) ? 8'h01 : 8'h00);
            chk($sformatf("lat_b_rise_%0d", k), {4'h0, b_rise}, (k == 3) ? 8'h01 : 8'h00);
        end
        a_sig = 4'hB;
        repeat (8) tick();
        chk("glt_pre", {4'h0, a_sync}, 8'h0B);
        a_sig = 4'hF;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) a_sig = 4'hB;
            chk($sformatf("glt3_sync_%0d", k), {4'h0, a_sync}, 8'h0B);
            chk($sformatf("glt3_pulse_%0d", k), {a_rise, a_fall}, 8'h00);
        end
        a_sig = 4'hF;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) a_sig = 4'hB;
            chk($sformatf("glt4_sync_%0d", k), {4'h0, a_sync}, (k >= 6 && k < 10) ? 8'h0F : 8'h0B);
            chk($sformatf("glt4_rise_%0d", k), {4'h0, a_rise}, (k == 6) ? 8'h04 : 8'h00);
            chk($sformatf("glt4_fall_%0d", k), {4'h0, a_fall}, (k == 10) ? 8'h04 : 8'h00);
        end
        a_sig = 4'h0;
        repeat (8) tick();
        chk("sim_pre", {4'h0, a_sync}, 8'h00);
        a_sig = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("sim_rise_%0d", k), {4'h0, a_rise}, (k == 6) ? 8'h0F : 8'h00);
            chk($sformatf("sim_any_%0d", k), {7'h0, a_any}, (k == 6) ? 8'h01 : 8'h00);
        end
        a_sig = 4'h0;
        repeat (4) tick();
        #2 rstn = 1'b0;
        #1;
        chk("arst_sync", {4'h0, a_sync}, 8'h05);
        chk("arst_pulse", {a_rise, a_fall}, 8'h00);
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("arst_sync_%0d", k), {4'h0, a_sync}, (k >= 6) ? 8'h00 : 8'h05);
            chk($sformatf("arst_fall_%0d", k), {4'h0, a_fall}, (k == 6) ? 8'h05 : 8'h00);
        end
`ifdef CDC_SYNC_STICKY_EN
        a_clr = 4'hF;
        tick();
        a_clr = 4'h0;
        tick();
        chk("evt_clr_all", {4'h0, a_evt}, 8'h00);
        a_sig = 4'h2;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("evt_set_%0d", k), {4'h0, a_evt}, (k >= 6) ? 8'h02 : 8'h00);
        end
        a_sig = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) a_clr = 4'h2;
        end
        a_clr = 4'h0;
        chk("evt_fall", {4'h0, a_fall}, 8'h02);
        chk("evt_set_wins", {4'h0, a_evt}, 8'h02);
        tick();
        chk("evt_hold", {4'h0, a_evt}, 8'h02);
        a_clr = 4'h2;
        tick();
        a_clr = 4'h0;
        chk("evt_clr", {4'h0, a_evt}, 8'h00);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
